gc_dram_array: RTL and testbench
================================

GC_DRAM_ARRAY -- requirements
Module: gc_dram_array

Interface
REQ-001 SHALL have parameter DATA_W, default 64, row width in bits.
REQ-002 SHALL have parameter DEPTH, default 128, row count (power of two, 2..1024); ADDR_W = log2(DEPTH).
REQ-003 SHALL have parameter RETENTION, default 5000, data retention time in clk cycles (>= 2).
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles (1..4).
REQ-005 SHALL have parameter URGENT_TH, default 1000, remaining-cycle threshold for an urgent refresh request (< RETENTION).
REQ-006 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have ports we/waddr/wdata  input  1/ADDR_W/DATA_W  user write strobe, row and data.
REQ-009 SHALL have ports re/raddr  input  1/ADDR_W  user read strobe and row.
REQ-010 SHALL have ports ref_en/ref_addr  input  1/ADDR_W  refresh strobe and row (internal read-writeback).
REQ-011 SHALL have ports rdata/rvalid/rerr  output  DATA_W/1/1  read data, valid pulse, read-error flag.
REQ-012 SHALL have ports urgent/urgent_addr  output  1/ADDR_W  some live row is at or below URGENT_TH, and the lowest such index.
REQ-013 SHALL have port ref_err  output  1  one-cycle pulse when a refresh targets an expired row.

Function
REQ-014 Each row SHALL hold data, a live bit and a remaining-life counter wide enough for RETENTION.
REQ-015 A write SHALL store wdata, set live=1, and load the counter with RETENTION-1.
REQ-016 A live row's counter SHALL decrement by 1 per cycle; on the cycle it would go below 0, live SHALL clear and data SHALL become X.
REQ-017 A refresh of a live row SHALL reload the counter with RETENTION-1 and leave data unchanged.
REQ-018 A refresh of an expired row SHALL leave the row expired and pulse ref_err one cycle later.
REQ-019 A write and a refresh to the same row in one cycle SHALL act as the write only; ref_err SHALL not pulse.
REQ-020 A read SHALL sample the row at issue; rvalid SHALL pulse exactly RD_LAT cycles later, with rdata presented on the same cycle.
REQ-021 A read of an expired row, or a read with we=1 and raddr==waddr, SHALL return rdata=X with rerr=1 alongside rvalid.
REQ-022 A read with ref_en=1 to the same row SHALL return the stored data with rerr=0.
REQ-023 Back-to-back reads SHALL be accepted every cycle; the pipeline SHALL be fully pipelined.
REQ-024 When rvalid=0, rdata SHALL hold its last value and rerr SHALL be 0.
REQ-025 urgent/urgent_addr SHALL be registered and SHALL reflect counter state of the previous cycle; expired rows are excluded.
REQ-026 When urgent=0, urgent_addr SHALL be 0.

Reset
REQ-027 rst SHALL clear all live bits and counters, zero rdata/rvalid/rerr/urgent/urgent_addr/ref_err, and flush in-flight reads with no rvalid.
REQ-028 Row data SHALL be unspecified (X) after reset; there is no reset of the data array.
REQ-029 A read issued in the cycle rst deasserts SHALL complete normally.

Structure
REQ-030 Package gc_dram_pkg SHALL hold default parameter constants and the function computing counter width from RETENTION.
REQ-031 Sub-module gc_row_timer (counter, live bit, load/decrement, urgent compare) SHALL be instantiated DEPTH times.
REQ-032 The lowest-index urgent row selection SHALL be a priority encoder in gc_dram_array.

Verification
REQ-033 Write row 5 = 0xA5A5..; read row 5 after 10 cycles -> rvalid at +RD_LAT, rdata=0xA5A5.., rerr=0.
REQ-034 Write row 3, idle RETENTION cycles, read row 3 -> rerr=1, rdata=X; refresh row 3 -> ref_err pulse.
REQ-035 Write row 7, refresh every 4000 cycles for 20000 cycles, read -> original data, rerr=0.
REQ-036 Write row 9 at t=0 -> urgent=1, urgent_addr=9 from cycle RETENTION-1-URGENT_TH+1; clears after refresh.
REQ-037 we and re both to row 2 same cycle -> rerr=1; we+ref_en same row -> write data kept, no ref_err.
REQ-038 Assert rst with 2 reads in flight (RD_LAT=3) -> no rvalid, all rows expired afterwards.

Source files
------------

// File: rtl/gc_dram_pkg.sv
// Shared constants and helpers for the retention-limited DRAM array model.
//   - default parameter values used by every file of the block
//   - cnt_width(): bits needed for a row life counter loaded with RETENTION-1
package gc_dram_pkg;

    localparam int DATA_W_DEF    = 64;
    localparam int DEPTH_DEF     = 128;
    localparam int RETENTION_DEF = 5000;
    localparam int RD_LAT_DEF    = 1;
    localparam int URGENT_TH_DEF = 1000;

    // Smallest width whose range covers 0..retention-1 (at least one bit).
    function automatic int cnt_width(input int retention);
        for (int w = 1; w < 32; w++) begin
            if ((1 << w) >= retention) return w;
        end
        return 32;
    endfunction

endpackage

// File: rtl/gc_dram_array_if.sv
// Bus bundle between a user and gc_dram_array.
//   master: drives write (we/waddr/wdata), read (re/raddr) and refresh
//           (ref_en/ref_addr) requests; receives rdata/rvalid/rerr,
//           urgent/urgent_addr and ref_err.
//   slave : the array side, directions reversed.
interface gc_dram_array_if
    import gc_dram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = $clog2(DEPTH_DEF)
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic              ref_en;
    logic [ADDR_W-1:0] ref_addr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rerr;
    logic              urgent;
    logic [ADDR_W-1:0] urgent_addr;
    logic              ref_err;

    modport master (
        output we, waddr, wdata, re, raddr, ref_en, ref_addr,
        input  rdata, rvalid, rerr, urgent, urgent_addr, ref_err
    );

    modport slave (
        input  we, waddr, wdata, re, raddr, ref_en, ref_addr,
        output rdata, rvalid, rerr, urgent, urgent_addr, ref_err
    );
endinterface

// File: rtl/gc_row_timer.sv
// Life tracker for one row: live bit plus remaining-life counter.
//   clk, rst  : clock, asynchronous active-high reset (row becomes expired)
//   wr_i      : row written this cycle -> live, counter = RETENTION-1
//   ref_i     : row refreshed this cycle -> reload only if still live
//   live_o    : row currently holds valid data
//   urgent_o  : row live with remaining life <= URGENT_TH (combinational)
module gc_row_timer
    import gc_dram_pkg::*;
#(
    parameter int RETENTION = RETENTION_DEF,
    parameter int URGENT_TH = URGENT_TH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic wr_i,
    input  logic ref_i,
    output logic live_o,
    output logic urgent_o
);
    localparam int               CNT_W   = cnt_width(RETENTION);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RETENTION - 1);
    localparam logic [CNT_W-1:0] CNT_TH  = CNT_W'(URGENT_TH);

    logic             live_q, live_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        live_d = live_q;
        cnt_d  = cnt_q;
        // A write wins over a same-row refresh; a refresh cannot revive
        // an expired row.
        if (wr_i || (ref_i && live_q)) begin
            live_d = 1'b1;
            cnt_d  = CNT_MAX;
        end else if (live_q) begin
            if (cnt_q == '0) begin
                live_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            live_q <= live_d;
            cnt_q  <= cnt_d;
        end
    end

    assign live_o   = live_q;
    assign urgent_o = live_q && (cnt_q <= CNT_TH);
endmodule

// File: rtl/gc_dram_array.sv
// DRAM-like storage array whose rows forget their contents RETENTION cycles
// after the last write or refresh.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of gc_dram_array_if
//              write  we/waddr/wdata, read re/raddr, refresh ref_en/ref_addr
//              rdata/rvalid/rerr : read result RD_LAT cycles after issue
//              urgent/urgent_addr: lowest live row near expiry (registered)
//              ref_err           : refresh hit an expired row (one cycle later)
module gc_dram_array
    import gc_dram_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int RETENTION = RETENTION_DEF,
    parameter int RD_LAT    = RD_LAT_DEF,
    parameter int URGENT_TH = URGENT_TH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    gc_dram_array_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  live;
    logic [DEPTH-1:0]  row_urgent;
    logic [DEPTH-1:0]  row_wr;
    logic [DEPTH-1:0]  row_ref;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_row
            assign row_wr[gi]  = bus.we     && (bus.waddr    == ADDR_W'(gi));
            assign row_ref[gi] = bus.ref_en && (bus.ref_addr == ADDR_W'(gi));
            gc_row_timer #(
                .RETENTION (RETENTION),
                .URGENT_TH (URGENT_TH)
            ) u_timer (
                .clk      (clk),
                .rst      (rst),
                .wr_i     (row_wr[gi]),
                .ref_i    (row_ref[gi]),
                .live_o   (live[gi]),
                .urgent_o (row_urgent[gi])
            );
        end
    endgenerate

    // Data array has no reset: an expired row's contents are meaningless.
    always_ff @(posedge clk) begin
        if (bus.we) mem[bus.waddr] <= bus.wdata;
    end

    // Read pipeline. Stage 0 samples the array at issue; each later stage
    // only captures when the stage before it holds a result, so the last
    // stage keeps presenting the most recent rdata between pulses.
    logic              rd_err;
    logic [DATA_W-1:0] pipe_data_q [RD_LAT];
    logic [RD_LAT-1:0] pipe_vld_q;
    logic [RD_LAT-1:0] pipe_err_q;

    // A read colliding with a same-row write sees an undefined old/new mix.
    assign rd_err = !live[bus.raddr] || (bus.we && (bus.waddr == bus.raddr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= '0;
            pipe_err_q <= '0;
            for (int s = 0; s < RD_LAT; s++) pipe_data_q[s] <= '0;
        end else begin
            pipe_vld_q[0] <= bus.re;
            pipe_err_q[0] <= bus.re && rd_err;
            if (bus.re) pipe_data_q[0] <= rd_err ? {DATA_W{1'bx}} : mem[bus.raddr];
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_vld_q[s] <= pipe_vld_q[s-1];
                pipe_err_q[s] <= pipe_err_q[s-1];
                if (pipe_vld_q[s-1]) pipe_data_q[s] <= pipe_data_q[s-1];
            end
        end
    end

    assign bus.rdata  = pipe_data_q[RD_LAT-1];
    assign bus.rvalid = pipe_vld_q[RD_LAT-1];
    assign bus.rerr   = pipe_err_q[RD_LAT-1];

    // Lowest-index urgent row: scan downwards so the last hit is the lowest.
    logic              urgent_q, urgent_d;
    logic [ADDR_W-1:0] urgent_addr_q, urgent_addr_d;
    logic              ref_err_q, ref_err_d;

    always_comb begin
        urgent_d      = 1'b0;
        urgent_addr_d = '0;
        for (int r = DEPTH - 1; r >= 0; r--) begin
            if (row_urgent[r]) begin
                urgent_d      = 1'b1;
                urgent_addr_d = ADDR_W'(r);
            end
        end
    end

    // A same-row write masks the refresh entirely, so no error for it.
    assign ref_err_d = bus.ref_en && !live[bus.ref_addr]
                       && !(bus.we && (bus.waddr == bus.ref_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            urgent_q      <= 1'b0;
            urgent_addr_q <= '0;
            ref_err_q     <= 1'b0;
        end else begin
            urgent_q      <= urgent_d;
            urgent_addr_q <= urgent_addr_d;
            ref_err_q     <= ref_err_d;
        end
    end

    assign bus.urgent      = urgent_q;
    assign bus.urgent_addr = urgent_addr_q;
    assign bus.ref_err     = ref_err_q;
endmodule

// File: tb/tb_gc_dram_array.sv
// Testbench for gc_dram_array: directed scenarios plus randomized traffic,
// all compared every cycle against a timestamp-based model of row lifetimes.
module tb_gc_dram_array;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int RET   = 5000;
    localparam int RDL   = 3;
    localparam int TH    = 1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gc_dram_array_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    gc_dram_array #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .RETENTION (RET),
        .RD_LAT    (RDL),
        .URGENT_TH (TH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A row is described by the clock edge of its last write/refresh; its
    // remaining life after edge n is RET-1-(n-load), live while that is >= 0.
    typedef struct {
        int            due;
        bit            err;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           rdq[$];
    logic [DW-1:0] m_data    [DEPTH];
    bit            m_written [DEPTH];
    int            m_load    [DEPTH];
    bit            lp        [DEPTH];
    int            cyc = 0;
    bit            e_rvalid, e_rerr, e_urgent, e_referr, e_known;
    logic [DW-1:0] e_rdata;
    int            e_uaddr;

    task automatic model_step();
        int  n;
        rd_t t;
        if (rst) begin
            cyc = 0;
            for (int r = 0; r < DEPTH; r++) m_written[r] = 1'b0;
            rdq.delete();
            e_rvalid = 0; e_rerr = 0; e_urgent = 0; e_uaddr = 0; e_referr = 0;
            e_rdata = '0; e_known = 1;
        end else begin
            cyc++;
            n = cyc - 1;
            for (int r = 0; r < DEPTH; r++)
                lp[r] = m_written[r] && ((n - m_load[r]) < RET);
            e_urgent = 0;
            e_uaddr  = 0;
            for (int r = 0; r < DEPTH; r++)
                if (!e_urgent && lp[r] && ((RET - 1 - (n - m_load[r])) <= TH)) begin
                    e_urgent = 1;
                    e_uaddr  = r;
                end
            e_referr = bus.ref_en && !lp[bus.ref_addr] && !(bus.we && bus.waddr == bus.ref_addr);
            if (bus.re) begin
                t.due  = cyc + RDL - 1;
                t.err  = !lp[bus.raddr] || (bus.we && bus.waddr == bus.raddr);
                t.data = m_data[bus.raddr];
                rdq.push_back(t);
            end
            e_rvalid = 0;
            e_rerr   = 0;
            if (rdq.size() > 0 && rdq[0].due == cyc) begin
                t = rdq.pop_front();
                e_rvalid = 1;
                e_rerr   = t.err;
                e_known  = !t.err;
                if (!t.err) e_rdata = t.data;
            end
            if (bus.we) begin
                m_data[bus.waddr]    = bus.wdata;
                m_written[bus.waddr] = 1'b1;
                m_load[bus.waddr]    = cyc;
            end
            if (bus.ref_en && lp[bus.ref_addr] && !(bus.we && bus.waddr == bus.ref_addr))
                m_load[bus.ref_addr] = cyc;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    task automatic compare();
        check("rvalid", 64'(bus.rvalid), 64'(e_rvalid));
        check("rerr", 64'(bus.rerr), 64'(e_rerr));
        if (e_known) check("rdata", 64'(bus.rdata), 64'(e_rdata));
        check("urgent", 64'(bus.urgent), 64'(e_urgent));
        check("urgent_addr", 64'(bus.urgent_addr), 64'(e_uaddr));
        check("ref_err", 64'(bus.ref_err), 64'(e_referr));
    endtask

    initial forever begin
        @(negedge clk);
        compare();
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.we = 1'b0; bus.re = 1'b0; bus.ref_en = 1'b0;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d);
        bus.we = 1'b1; bus.waddr = AW'(a); bus.wdata = d;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic do_ref(input int a);
        bus.ref_en = 1'b1; bus.ref_addr = AW'(a);
        @(negedge clk);
        bus.ref_en = 1'b0;
    endtask

    task automatic read_check(input int a, input bit exp_err, input logic [DW-1:0] exp_d,
                              input string name);
        bus.re = 1'b1; bus.raddr = AW'(a);
        @(negedge clk);
        bus.re = 1'b0;
        repeat (RDL - 1) @(negedge clk);
        check({name, "_rvalid"}, 64'(bus.rvalid), 64'd1);
        check({name, "_rerr"}, 64'(bus.rerr), 64'(exp_err));
        if (!exp_err) check({name, "_rdata"}, 64'(bus.rdata), 64'(exp_d));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int vcount;
        int ecount;
        bus.we = 0; bus.waddr = '0; bus.wdata = '0;
        bus.re = 0; bus.raddr = '0; bus.ref_en = 0; bus.ref_addr = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rvalid", 64'(bus.rvalid), 64'd0);
        check("reset_rdata", 64'(bus.rdata), 64'd0);
        check("reset_urgent", 64'(bus.urgent), 64'd0);
        check("reset_ref_err", 64'(bus.ref_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Write and read the same row in one cycle -> error.
        bus.we = 1; bus.waddr = 2; bus.wdata = 64'h0202_0202_0202_0202;
        bus.re = 1; bus.raddr = 2;
        @(negedge clk);
        idle();
        repeat (RDL - 1) @(negedge clk);
        check("wr_rd_same_rvalid", 64'(bus.rvalid), 64'd1);
        check("wr_rd_same_rerr", 64'(bus.rerr), 64'd1);

        // Write + refresh of an expired row: write wins, no ref_err.
        bus.we = 1; bus.waddr = 11; bus.wdata = 64'h1111_2222_3333_4444;
        bus.ref_en = 1; bus.ref_addr = 11;
        @(negedge clk);
        idle();
        check("wr_ref_no_ref_err", 64'(bus.ref_err), 64'd0);
        read_check(11, 1'b0, 64'h1111_2222_3333_4444, "wr_ref_data");

        // Two reads in flight, then reset: they must never return.
        bus.re = 1; bus.raddr = 11;
        @(negedge clk);
        bus.raddr = 2;
        @(negedge clk);
        idle();
        rst = 1'b1;
        vcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rvalid) vcount++;
        end
        check("flush_no_rvalid", 64'(vcount), 64'd0);
        // Read issued in the cycle reset drops completes; row 11 is gone.
        rst = 1'b0;
        read_check(11, 1'b1, '0, "post_reset_read");

        // Every row expired after reset; reads accepted back to back.
        ecount = 0;
        for (int i = 0; i < DEPTH + RDL; i++) begin
            bus.re = (i < DEPTH);
            bus.raddr = AW'(i);
            @(negedge clk);
            if (bus.rvalid && bus.rerr) ecount++;
        end
        bus.re = 0;
        check("all_rows_expired", 64'(ecount), 64'(DEPTH));

        // Urgent timing for a single live row 9.
        do_write(9, 64'h9999_9999_9999_9999);
        repeat (RET - TH - 1) @(negedge clk);
        check("urgent_before", 64'(bus.urgent), 64'd0);
        @(negedge clk);
        check("urgent_set", 64'(bus.urgent), 64'd1);
        check("urgent_addr_9", 64'(bus.urgent_addr), 64'd9);
        do_ref(9);
        check("ref_live_no_err", 64'(bus.ref_err), 64'd0);
        @(negedge clk);
        check("urgent_cleared", 64'(bus.urgent), 64'd0);
        check("urgent_addr_zero", 64'(bus.urgent_addr), 64'd0);

        // Basic write then read.
        do_write(5, 64'hA5A5_A5A5_A5A5_A5A5);
        repeat (10) @(negedge clk);
        read_check(5, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5, "row5");

        // Expiry boundary: row 4 read on its last live cycle, row 3 after.
        do_write(3, 64'h3333_3333_3333_3333);
        do_write(4, 64'h4444_4444_4444_4444);
        repeat (RET - 1) @(negedge clk);
        read_check(4, 1'b0, 64'h4444_4444_4444_4444, "row4_last_live");
        read_check(3, 1'b1, '0, "row3_expired");
        do_ref(3);
        check("ref_expired_err", 64'(bus.ref_err), 64'd1);
        @(negedge clk);
        check("ref_err_pulse_end", 64'(bus.ref_err), 64'd0);

        // Row 7 kept alive by periodic refresh under random traffic.
        do_write(7, 64'h7777_0000_7777_0000);
        for (int i = 0; i < 20000; i++) begin
            bus.we    = ($urandom_range(0, 255) == 0);
            bus.waddr = AW'($urandom_range(0, DEPTH - 1));
            if (bus.waddr == 7) bus.waddr = 8;
            bus.wdata = {$urandom, $urandom};
            bus.re    = ($urandom_range(0, 3) == 0);
            bus.raddr = AW'($urandom_range(0, DEPTH - 1));
            bus.ref_en   = ($urandom_range(0, 511) == 0);
            bus.ref_addr = AW'($urandom_range(0, DEPTH - 1));
            if (i % 4000 == 0) begin
                bus.ref_en = 1; bus.ref_addr = 7;
            end
            @(negedge clk);
        end
        idle();
        repeat (RDL + 1) @(negedge clk);
        read_check(7, 1'b0, 64'h7777_0000_7777_0000, "row7_refreshed");
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
